// File: rtl/pla_cube_engine.sv
// Run-time programmable two-level PLA (AND-plane of cubes, OR-plane of outputs)
// with a two-stage valid/ready pipeline and a saturating hit counter.
module pla_cube_engine #(
  parameter int N_IN    = 12,
  parameter int N_CUBES = 8,
  parameter int N_OUT   = 1,
  parameter int CNT_W   = 16,
  localparam int AW     = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic [N_OUT-1:0]   cfg_out,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_y,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt
);

  logic [N_CUBES-1:0] en_q;
  logic [N_IN-1:0]    care_q [N_CUBES];
  logic [N_IN-1:0]    val_q  [N_CUBES];
  logic [N_OUT-1:0]   out_q  [N_CUBES];

  logic [N_CUBES-1:0] match_d;
  logic [N_CUBES-1:0] s1_match_q;
  logic               s1_valid_q;
  logic [N_OUT-1:0]   y_d;
  logic [N_OUT-1:0]   s2_y_q;
  logic               s2_valid_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_d;

  logic s1_adv;
  logic s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int c = 0; c < N_CUBES; c++) begin
        care_q[c] <= '0;
        val_q[c]  <= '0;
        out_q[c]  <= '0;
      end
    end else if (cfg_we) begin
      en_q[cfg_addr]   <= cfg_en;
      care_q[cfg_addr] <= cfg_care;
      val_q[cfg_addr]  <= cfg_val;
      out_q[cfg_addr]  <= cfg_out;
    end
  end

  always_comb begin
    match_d = '0;
    for (int c = 0; c < N_CUBES; c++) begin
      match_d[c] = en_q[c] & ~|((in_x ^ val_q[c]) & care_q[c]);
    end
  end

  always_comb begin
    y_d = '0;
    for (int c = 0; c < N_CUBES; c++) begin
      if (s1_match_q[c]) y_d = y_d | out_q[c];
    end
  end

  // Each stage may load whenever the stage ahead of it is empty or draining.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_match_q <= match_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_y_q <= y_d;
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (s2_valid_q && out_ready && (|s2_y_q) && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_pla_cube_engine.sv
// Scoreboard bench for pla_cube_engine: expected results are queued on input
// acceptance and compared in order on every output transfer.
module tb_pla_cube_engine;
  localparam int N_IN    = 12;
  localparam int N_CUBES = 8;
  localparam int N_OUT   = 2;
  localparam int CNT_W   = 4;
  localparam int AW      = 3;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic             cfg_en;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic [N_OUT-1:0] cfg_out;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N_OUT-1:0] out_y;
  logic             cnt_clr;
  logic [CNT_W-1:0] hit_cnt;

  pla_cube_engine #(.N_IN(N_IN), .N_CUBES(N_CUBES), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic             m_en   [N_CUBES];
  logic [N_IN-1:0]  m_care [N_CUBES];
  logic [N_IN-1:0]  m_val  [N_CUBES];
  logic [N_OUT-1:0] m_out  [N_CUBES];

  logic [N_OUT-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_hit = '0;
  int               occ = 0;
  int               n_delivered = 0;
  bit               stall_q = 0;
  logic [N_OUT-1:0] stall_y;
  logic [N_OUT-1:0] mon_e;
  bit               bp_mode = 0;
  logic             or_hold = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = bp_mode ? ($urandom_range(0, 1) != 0) : or_hold;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= 0;
    else        occ <= occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
  end

  function automatic logic [N_OUT-1:0] model_y(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] y = '0;
    for (int c = 0; c < N_CUBES; c++)
      if (m_en[c] && (((x ^ m_val[c]) & m_care[c]) == '0)) y = y | m_out[c];
    return y;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (in_ready !== ((occ < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready: got %b want %b (occ=%0d out_ready=%b)", in_ready, ((occ < 2) || out_ready), occ, out_ready);
      end
      n_checks++;
      if (hit_cnt !== exp_hit) begin
        n_fail++;
        $display("FAIL hit_cnt_track: got %0d want %0d", hit_cnt, exp_hit);
      end
      if (stall_q) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== stall_y) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b y=%b want valid=1 y=%b", out_valid, out_y, stall_y);
        end
      end
      stall_q = out_valid && !out_ready;
      stall_y = out_y;
      if (cnt_clr) exp_hit = '0;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got y=%b want no output", out_y);
        end else begin
          mon_e = exp_q.pop_front();
          n_delivered++;
          if (out_y !== mon_e) begin
            n_fail++;
            $display("FAIL out_y: got %b want %b", out_y, mon_e);
          end
          if (!cnt_clr && mon_e != '0 && exp_hit != {CNT_W{1'b1}}) exp_hit = exp_hit + 1'b1;
        end
      end
    end
  end

  task automatic clear_model();
    for (int c = 0; c < N_CUBES; c++) begin
      m_en[c] = 1'b0; m_care[c] = '0; m_val[c] = '0; m_out[c] = '0;
    end
  endtask

  task automatic cfg_write(input int c, input logic en, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] val, input logic [N_OUT-1:0] o);
    cfg_we = 1'b1; cfg_addr = AW'(c); cfg_en = en; cfg_care = care; cfg_val = val; cfg_out = o;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_en[c] = en; m_care[c] = care; m_val[c] = val; m_out[c] = o;
  endtask

  task automatic drive_vec(input logic [N_IN-1:0] x);
    bit done = 0;
    in_valid = 1'b1; in_x = x;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model_y(x));
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drive_timeout: got no acceptance of x=%h want acceptance within 100 cycles", x);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_care = '0; cfg_val = '0;
    cfg_out = '0; in_valid = 1'b0; in_x = '0; cnt_clr = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || hit_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b y=%b cnt=%0d rdy=%b want 0 0 0 1", out_valid, out_y, hit_cnt, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_vec(12'hFFF);
    drive_vec(12'h000);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_single_cube();
    cfg_write(0, 1'b1, 12'hFFF, 12'h0E3, 2'b01);
    drive_vec(12'h0E3);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 2'b01) begin
      n_fail++;
      $display("FAIL latency_due: got valid=%b y=%b want 1 01", out_valid, out_y);
    end
    @(posedge clk); #1;
    drive_vec(12'h0E2);
    drive_vec(12'h8E3);
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (hit_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL single_hit_cnt: got %0d want 1", hit_cnt);
    end
  endtask

  task automatic test_or_plane();
    cfg_write(1, 1'b1, 12'h001, 12'h001, 2'b10);
    cfg_write(2, 1'b1, 12'h000, 12'h000, 2'b01);
    drive_vec(12'h001);
    drive_vec(12'h000);
    drive_vec(12'h0E3);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [N_IN-1:0] xs [10] = '{12'h0E3, 12'h001, 12'h000, 12'h0E2, 12'h8E3,
                                 12'h0E3, 12'h7FF, 12'h001, 12'h0E3, 12'h002};
    int start = n_delivered;
    bp_mode = 1;
    for (int i = 0; i < 10; i++) drive_vec(xs[i]);
    in_valid = 1'b0;
    wait_drain();
    bp_mode = 0;
    @(posedge clk); #1;
    n_checks++;
    if (n_delivered - start != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results want 10", n_delivered - start);
    end
  endtask

  task automatic test_config_race();
    cfg_write(2, 1'b0, 12'h000, 12'h000, 2'b01);
    in_valid = 1'b1; in_x = 12'h0E3;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_en = 1'b0; cfg_care = 12'hFFF; cfg_val = 12'h0E3; cfg_out = 2'b01;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL race_ready: got %b want 1", in_ready);
    end else begin
      exp_q.push_back(model_y(12'h0E3));
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_en[0] = 1'b0;
    drive_vec(12'h0E3);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_counter();
    cfg_write(2, 1'b1, 12'h000, 12'h000, 2'b01);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) drive_vec(N_IN'(i * 37));
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (hit_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %0d want 15", hit_cnt);
    end
    cnt_clr = 1'b1;
    drive_vec(12'h000);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    cnt_clr = 1'b0;
    n_checks++;
    if (hit_cnt !== 4'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cnt_clr_wins: got cnt=%0d pending=%0d want 0 0", hit_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    drive_vec(12'h00F);
    drive_vec(12'h0F0);
    drive_vec(12'hF00);
    in_valid = 1'b0;
    wait_drain();
    or_hold = 1'b0;
    drive_vec(12'h123);
    drive_vec(12'h456);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || hit_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_reset: got valid=%b y=%b cnt=%0d rdy=%b want 0 0 0 1", out_valid, out_y, hit_cnt, in_ready);
    end
    exp_q.delete();
    exp_hit = '0;
    stall_q = 0;
    clear_model();
    or_hold = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_vec(12'h0E3);
    drive_vec(12'hFFF);
    drive_vec(12'h001);
    in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_cube();
    test_or_plane();
    test_back_to_back();
    test_config_race();
    test_counter();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
